// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: the controller uses the master view,
// while the keypad and key consumer use the slave view.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_err;
    logic       busy;

    modport master (
        input  row,
        output col,
        output key_valid,
        output key_code,
        output key_err,
        output busy
    );

    modport slave (
        output row,
        input  col,
        input  key_valid,
        input  key_code,
        input  key_err,
        input  busy
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with debounce, ghost/multi-key detection and registered strobes.
// Define KEYPAD_REPEAT_EN to add auto-repeat of a held single key.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 4,
    parameter int unsigned DEB_CYC    = 8,
    parameter int unsigned REPEAT_DLY = 64,
    parameter int unsigned REPEAT_PER = 16
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master bus_io
);
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] DEB_TGT  = 16'(DEB_CYC);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic is_one_hot(input logic [3:0] r);
        return (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_q, col_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  pat_q, pat_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_err_q, key_err_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_inc;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] DLY_TGT = 16'(REPEAT_DLY);
    localparam logic [15:0] PER_TGT = 16'(REPEAT_PER);
    logic [15:0] rep_q, rep_d;
    logic        rep_phase_q, rep_phase_d;
`endif

    // Next-state and output decode; strobes default low and only fire on entry to or within HELD.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_err_d   = 1'b0;
        cnt_inc     = sat_inc(cnt_q);
`ifdef KEYPAD_REPEAT_EN
        rep_d       = 16'd0;
        rep_phase_d = 1'b0;
`endif
        case (state_q)
            SCAN: begin
                if (div_q >= DIV_LAST) begin
                    div_d = 16'd0;
                    if (bus_io.row != 4'd0) begin
                        pat_d   = bus_io.row;
                        cnt_d   = 16'd0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    div_d = sat_inc(div_q);
                end
            end
            DEBOUNCE: begin
                if (bus_io.row == pat_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DEB_TGT) begin
                        cnt_d   = 16'd0;
                        state_d = HELD;
                        if (is_one_hot(pat_q)) begin
                            key_valid_d = 1'b1;
                            key_code_d  = {row_index(pat_q), col_idx_q};
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end else begin
                        state_d = DEBOUNCE;
                    end
                end else begin
                    // A bounce abandons this column and resumes scanning at the next one.
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    div_d     = 16'd0;
                    cnt_d     = 16'd0;
                end
            end
            HELD: begin
                if (bus_io.row == 4'd0) begin
                    state_d = RELEASE;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_d       = sat_inc(rep_q);
                    rep_phase_d = rep_phase_q;
                    if (is_one_hot(pat_q) &&
                        (sat_inc(rep_q) >= (rep_phase_q ? PER_TGT : DLY_TGT))) begin
                        key_valid_d = 1'b1;
                        rep_d       = 16'd0;
                        rep_phase_d = 1'b1;
                    end else begin
                        key_valid_d = 1'b0;
                    end
`endif
                end
            end
            RELEASE: begin
                if (bus_io.row == 4'd0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DEB_TGT) begin
                        state_d   = SCAN;
                        col_idx_d = 2'd0;
                        div_d     = 16'd0;
                        cnt_d     = 16'd0;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    state_d = HELD;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d   = SCAN;
                col_idx_d = 2'd0;
                div_d     = 16'd0;
                cnt_d     = 16'd0;
            end
        endcase
        col_d  = 4'b0001 << col_idx_d;
        busy_d = (state_d != SCAN);
    end

    // State and registered outputs; reset aborts any pending strobe and restarts at column 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b0001;
            div_q       <= 16'd0;
            cnt_q       <= 16'd0;
            pat_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= 16'd0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            busy_q      <= busy_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

    assign bus_io.col       = col_q;
    assign bus_io.key_valid = key_valid_q;
    assign bus_io.key_code  = key_code_q;
    assign bus_io.key_err   = key_err_q;
    assign bus_io.busy      = busy_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed self-checking bench for keypad_scan_ctrl with default parameters.
// Define KEYPAD_REPEAT_EN to also exercise the auto-repeat sequence.
module tb_keypad_scan_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   kv_cnt = 0;
    int   ke_cnt = 0;
    int   both_cnt = 0;
    logic [3:0] exp_col;
    logic       exp_kv;

    keypad_if kp();

    keypad_scan_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (kp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (kp.key_valid === 1'b1) kv_cnt++;
        if (kp.key_err === 1'b1) ke_cnt++;
        if ((kp.key_valid === 1'b1) && (kp.key_err === 1'b1)) both_cnt++;
    endtask

    initial begin
        rst    = 1'b1;
        kp.row = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col",   16'(kp.col),       16'h0001);
        check("rst_kv",    16'(kp.key_valid), 16'h0000);
        check("rst_ke",    16'(kp.key_err),   16'h0000);
        check("rst_code",  16'(kp.key_code),  16'h0000);
        check("rst_busy",  16'(kp.busy),      16'h0000);
        rst = 1'b0;

        // Idle scan: four cycles per column, no activity.
        kv_cnt = 0; ke_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            exp_col = 4'b0001 << ((k / 4) % 4);
            check("idle_col",  16'(kp.col),  16'(exp_col));
            check("idle_busy", 16'(kp.busy), 16'h0000);
            tick();
        end
        check("idle_kv_cnt", 16'(kv_cnt), 16'h0000);
        check("idle_ke_cnt", 16'(ke_cnt), 16'h0000);

        // Single key row 2 on column 1, held 200 cycles.
        kv_cnt = 0;
        repeat (4) tick();
        check("press_pre_col", 16'(kp.col), 16'h0002);
        kp.row = 4'b0100;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (t == 3) check("press_busy_lo", 16'(kp.busy), 16'h0000);
            if (t == 4) begin
                check("press_busy_hi", 16'(kp.busy), 16'h0001);
                check("press_col_frz", 16'(kp.col),  16'h0002);
            end
            if (t == 11) check("press_kv_early", 16'(kp.key_valid), 16'h0000);
            if (t == 12) begin
                check("press_kv",   16'(kp.key_valid), 16'h0001);
                check("press_code", 16'(kp.key_code),  16'h0009);
            end
            if (t == 13) check("press_kv_1cyc", 16'(kp.key_valid), 16'h0000);
        end
`ifdef KEYPAD_REPEAT_EN
        check("press_kv_cnt", 16'(kv_cnt), 16'h0009);
`else
        check("press_kv_cnt", 16'(kv_cnt), 16'h0001);
`endif
        kp.row = 4'd0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t == 8) check("rel_busy_hi", 16'(kp.busy), 16'h0001);
            if (t == 9) begin
                check("rel_busy_lo", 16'(kp.busy), 16'h0000);
                check("rel_col0",    16'(kp.col),  16'h0001);
            end
        end

        // Bounce: three matching cycles then release.
        kv_cnt = 0;
        repeat (3) tick();
        kp.row = 4'b1000;
        tick();
        check("bounce_busy",  16'(kp.busy), 16'h0001);
        check("bounce_col",   16'(kp.col),  16'h0001);
        tick();
        tick();
        kp.row = 4'd0;
        tick();
        check("bounce_scan",  16'(kp.busy), 16'h0000);
        check("bounce_next",  16'(kp.col),  16'h0002);
        repeat (4) tick();
        check("bounce_resume", 16'(kp.col), 16'h0004);
        check("bounce_kv_cnt", 16'(kv_cnt), 16'h0000);

        // Two rows at once on column 2: error strobe only.
        kv_cnt = 0; ke_cnt = 0;
        kp.row = 4'b0011;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 11) check("ghost_ke_early", 16'(kp.key_err), 16'h0000);
            if (t == 12) check("ghost_ke",       16'(kp.key_err), 16'h0001);
            if (t == 13) check("ghost_ke_1cyc",  16'(kp.key_err), 16'h0000);
        end
        check("ghost_ke_cnt", 16'(ke_cnt),      16'h0001);
        check("ghost_kv_cnt", 16'(kv_cnt),      16'h0000);
        check("ghost_code",   16'(kp.key_code), 16'h0009);
        kp.row = 4'd0;
        repeat (9) tick();
        check("ghost_rel_busy", 16'(kp.busy), 16'h0000);
        check("ghost_rel_col",  16'(kp.col),  16'h0001);

        // Reset in the middle of a debounce on column 1.
        kv_cnt = 0;
        repeat (4) tick();
        kp.row = 4'b0010;
        repeat (4) tick();
        check("mrst_deb_busy", 16'(kp.busy), 16'h0001);
        check("mrst_deb_col",  16'(kp.col),  16'h0002);
        repeat (3) tick();
        rst    = 1'b1;
        kp.row = 4'd0;
        #1;
        check("mrst_col",  16'(kp.col),      16'h0001);
        check("mrst_busy", 16'(kp.busy),     16'h0000);
        check("mrst_code", 16'(kp.key_code), 16'h0000);
        tick();
        tick();
        check("mrst_kv", 16'(kp.key_valid), 16'h0000);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_col = 4'b0001 << ((k / 4) % 4);
            check("mrst_scan_col", 16'(kp.col), 16'(exp_col));
            tick();
        end
        check("mrst_kv_cnt", 16'(kv_cnt), 16'h0000);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat: row 0 on column 0 held 120 cycles.
        repeat (4) tick();
        kp.row = 4'b0001;
        for (int t = 1; t <= 120; t++) begin
            tick();
            exp_kv = (t == 12) || (t == 76) || (t == 92) || (t == 108);
            check("rep_kv", 16'(kp.key_valid), 16'(exp_kv));
            if (exp_kv) check("rep_code", 16'(kp.key_code), 16'h0000);
        end
        kp.row = 4'd0;
        repeat (9) tick();
        check("rep_rel_busy", 16'(kp.busy), 16'h0000);
`endif

        check("never_both", 16'(both_cnt), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
